// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: queues DATA_BITS-wide words and sends start/data/[parity]/stop frames.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [AW:0]          count_reg;
    logic                 overflow_reg;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    // Full is judged on the registered count, so a same-edge pop never frees a slot for a write.
    assign full       = (count_reg == DEPTH);
    assign push       = wr_valid && !full;
    assign wr_ready   = !full;
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;
    assign head       = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            overflow_reg <= wr_valid && full;
        end
    end

    // ---------------- Serialiser ----------------
    state_t               state_reg,    state_next;
    logic [CW-1:0]        baud_cnt_reg, baud_cnt_next;
    logic [BW-1:0]        bit_cnt_reg,  bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic                 tx_reg,       tx_next;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_reg,   parity_next;
`endif

    assign bit_end = (baud_cnt_reg == BAUD_LAST);
    assign busy    = (state_reg != IDLE);
    assign tx      = tx_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = bit_end ? '0 : baud_cnt_reg + 1'b1;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        pop           = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity_reg;
`endif

        case (state_reg)
            IDLE: begin
                baud_cnt_next = '0;
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next   = STOP;
                    bit_cnt_next = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_reg == STOP_LAST) begin
                        bit_cnt_next = '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (count_reg != '0) begin
                            pop        = 1'b1;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
            end
        endcase

        if (pop) begin
            shift_next  = head;
`ifdef UART_TX_PARITY_EN
            parity_next = ^head;
`endif
        end

        // tx is registered, so it is derived from the state being entered.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a line receiver decodes frames, tasks compare against queued expectations.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int BD  = 4;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P   = 1;
`else
    localparam int P   = 0;
`endif
    localparam int FB  = 1 + DB + P + 1;   // bits per frame, main instance
    localparam int FB2 = 1 + 7 + P + 2;    // bits per frame, 7-bit / 2-stop instance

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready, overflow, busy, tx;
    logic [2:0] fifo_count;

    logic [6:0] wr_data2 = '0;
    logic       wr_valid2 = 1'b0;
    logic       wr_ready2, overflow2, busy2, tx2;
    logic [2:0] fifo_count2;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(DB), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .overflow(overflow), .fifo_count(fifo_count),
        .busy(busy), .tx(tx)
    );

    uart_tx_fifo #(.BAUD_DIV(BD), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .wr_data(wr_data2), .wr_valid(wr_valid2),
        .wr_ready(wr_ready2), .overflow(overflow2), .fifo_count(fifo_count2),
        .busy(busy2), .tx(tx2)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       start_bit;
        logic       par;
        logic       stop_bit;
        int         start_cyc;
    } frame_t;

    frame_t     rxq[$];
    logic [7:0] expq[$];

    // Line receiver: finds the start bit, samples mid-bit, abandons the frame on reset.
    initial begin : receiver
        frame_t f;
        logic   bits [FB];
        bit     aborted;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                f.start_cyc = cyc;
                aborted = 1'b0;
                for (int k = 1; k <= (FB - 1) * BD + BD / 2; k++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if ((k % BD) == BD / 2) bits[k / BD] = tx;
                end
                if (!aborted) begin
                    f.start_bit = bits[0];
                    for (int i = 0; i < DB; i++) f.data[i] = bits[1 + i];
                    f.par      = (P == 1) ? bits[1 + DB] : 1'b0;
                    f.stop_bit = bits[FB - 1];
                    rxq.push_back(f);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic get_frame(output frame_t f, output bit got);
        got = 1'b0;
        for (int i = 0; i < 400 && rxq.size() == 0; i++) @(negedge clk);
        if (rxq.size() > 0) begin
            f = rxq.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic settle();
        repeat (FB * BD + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 7;
        if (tx !== 1'b1)          begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        if (fifo_count !== 3'd0)  begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        if (wr_ready !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %b expected 1", wr_ready); end
        if (tx2 !== 1'b1)         begin errors++; $display("FAIL reset_tx2: got %b expected 1", tx2); end
        if (busy2 !== 1'b0)       begin errors++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
        reset = 1'b0;
        @(negedge clk);
        $display("reset: released");
    endtask

    task automatic test_single_frame();
        logic [7:0] d;
        logic       exp_bits [FB];
        frame_t     f;
        bit         got;
        d = 8'h55;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) exp_bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        exp_bits[1 + DB] = ^d;
`endif
        exp_bits[FB - 1] = 1'b1;

        wr_data = d; wr_valid = 1'b1; expq.push_back(d);
        @(negedge clk);
        wr_valid = 1'b0;
        checks += 3;
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL single_busy_pre: got %b expected 0", busy); end
        if (tx !== 1'b1)         begin errors++; $display("FAIL single_tx_pre: got %b expected 1", tx); end
        for (int i = 0; i < FB * BD; i++) begin
            @(negedge clk);
            checks += 2;
            if (tx !== exp_bits[i / BD]) begin
                errors++; $display("FAIL single_tx[%0d]: got %b expected %b", i, tx, exp_bits[i / BD]);
            end
            if (busy !== 1'b1) begin
                errors++; $display("FAIL single_busy[%0d]: got %b expected 1", i, busy);
            end
        end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_post: got %b expected 0", busy); end
        if (tx !== 1'b1)   begin errors++; $display("FAIL single_tx_post: got %b expected 1", tx); end
        get_frame(f, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL single_rx: got no frame expected %02h", d);
        end else begin
            d = expq.pop_front();
            checks++;
            if (f.data !== d) begin errors++; $display("FAIL single_data: got %02h expected %02h", f.data, d); end
            $display("single: frame data=%02h", f.data);
        end
        settle();
    endtask

    task automatic test_parity();
        logic [7:0] vals [2];
        frame_t     f;
        bit         got;
        int         prev_start;
        vals[0] = 8'h55; vals[1] = 8'h07;
        for (int i = 0; i < 2; i++) begin
            wr_data = vals[i]; wr_valid = 1'b1; expq.push_back(vals[i]);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        prev_start = 0;
        for (int i = 0; i < 2; i++) begin
            get_frame(f, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL parity_rx[%0d]: got no frame expected one", i);
            end else begin
                logic [7:0] e;
                e = expq.pop_front();
                checks += 3;
                if (f.data !== e)         begin errors++; $display("FAIL parity_data[%0d]: got %02h expected %02h", i, f.data, e); end
                if (f.start_bit !== 1'b0) begin errors++; $display("FAIL parity_start[%0d]: got %b expected 0", i, f.start_bit); end
                if (f.stop_bit !== 1'b1)  begin errors++; $display("FAIL parity_stop[%0d]: got %b expected 1", i, f.stop_bit); end
`ifdef UART_TX_PARITY_EN
                checks++;
                if (f.par !== ^e) begin errors++; $display("FAIL parity_bit[%0d]: got %b expected %b", i, f.par, ^e); end
`endif
                if (i == 1) begin
                    checks++;
                    if (f.start_cyc - prev_start != FB * BD) begin
                        errors++; $display("FAIL parity_frame_len: got %0d expected %0d", f.start_cyc - prev_start, FB * BD);
                    end
                end
                prev_start = f.start_cyc;
                $display("parity: frame data=%02h par=%b", f.data, f.par);
            end
        end
        settle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals     [6];
        bit         exp_rdy  [6];
        int         exp_cnt  [6];
        frame_t     f;
        bit         got;
        int         prev_start;
        for (int i = 0; i < 6; i++) begin
            vals[i]    = 8'(8'h11 * (i + 1));
            exp_rdy[i] = (i < 5);
        end
        exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 2; exp_cnt[3] = 3; exp_cnt[4] = 4; exp_cnt[5] = 4;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                checks++;
                if (fifo_count !== 3'(exp_cnt[i - 1])) begin
                    errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", i - 1, fifo_count, exp_cnt[i - 1]);
                end
            end
            checks += 2;
            if (wr_ready !== exp_rdy[i]) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, wr_ready, exp_rdy[i]); end
            if (overflow !== 1'b0)       begin errors++; $display("FAIL b2b_ovf_early[%0d]: got %b expected 0", i, overflow); end
            wr_data = vals[i]; wr_valid = 1'b1;
            if (exp_rdy[i]) expq.push_back(vals[i]);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        checks += 2;
        if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_peak: got %0d expected 4", fifo_count); end
        if (overflow !== 1'b1)   begin errors++; $display("FAIL b2b_ovf: got %b expected 1", overflow); end
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_pulse: got %b expected 0", overflow); end
        prev_start = 0;
        for (int i = 0; i < 5; i++) begin
            get_frame(f, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL b2b_rx[%0d]: got no frame expected one", i);
            end else begin
                logic [7:0] e;
                e = expq.pop_front();
                checks++;
                if (f.data !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %02h expected %02h", i, f.data, e); end
                if (i > 0) begin
                    checks++;
                    if (f.start_cyc - prev_start != FB * BD) begin
                        errors++; $display("FAIL b2b_gap[%0d]: got %0d expected %0d", i, f.start_cyc - prev_start, FB * BD);
                    end
                end
                prev_start = f.start_cyc;
                $display("b2b: frame %0d data=%02h", i, f.data);
            end
        end
        settle();
        checks++;
        if (rxq.size() != 0) begin errors++; $display("FAIL b2b_extra: got %0d extra frames expected 0", rxq.size()); end
    endtask

    task automatic test_no_gap();
        frame_t f0, f1;
        bit     got0, got1;
        int     idle_cycles;
        logic [7:0] e;
        wr_data = 8'h00; wr_valid = 1'b1; expq.push_back(8'h00);
        @(negedge clk);
        wr_data = 8'hFF; expq.push_back(8'hFF);
        @(negedge clk);
        wr_valid = 1'b0;
        idle_cycles = 0;
        for (int i = 0; i < 2 * FB * BD; i++) begin
            if (busy !== 1'b1) idle_cycles++;
            @(negedge clk);
        end
        checks += 2;
        if (idle_cycles != 0) begin errors++; $display("FAIL nogap_busy: got %0d idle cycles expected 0", idle_cycles); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL nogap_end: got %b expected 0", busy); end
        get_frame(f0, got0);
        get_frame(f1, got1);
        checks++;
        if (!(got0 && got1)) begin
            errors++; $display("FAIL nogap_rx: got %0d frames expected 2", int'(got0) + int'(got1));
        end else begin
            checks += 3;
            e = expq.pop_front();
            if (f0.data !== e) begin errors++; $display("FAIL nogap_data0: got %02h expected %02h", f0.data, e); end
            e = expq.pop_front();
            if (f1.data !== e) begin errors++; $display("FAIL nogap_data1: got %02h expected %02h", f1.data, e); end
            if (f1.start_cyc - f0.start_cyc != FB * BD) begin
                errors++; $display("FAIL nogap_spacing: got %0d expected %0d", f1.start_cyc - f0.start_cyc, FB * BD);
            end
            $display("nogap: frames %02h %02h spacing=%0d", f0.data, f1.data, f1.start_cyc - f0.start_cyc);
        end
        settle();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] vals [3];
        frame_t     f;
        bit         got;
        logic [7:0] e;
        vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'h96;
        for (int i = 0; i < 3; i++) begin
            wr_data = vals[i]; wr_valid = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        repeat (16) @(negedge clk);
        checks += 2;
        if (tx !== vals[0][3])   begin errors++; $display("FAIL rst_mid_bit3: got %b expected %b", tx, vals[0][3]); end
        if (fifo_count !== 3'd2) begin errors++; $display("FAIL rst_mid_count: got %0d expected 2", fifo_count); end
        reset = 1'b1;
        #1;
        checks += 4;
        if (tx !== 1'b1)         begin errors++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_mid_fcount: got %0d expected 0", fifo_count); end
        if (wr_ready !== 1'b1)   begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", wr_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rxq.delete();
        @(negedge clk);
        wr_data = 8'h3C; wr_valid = 1'b1; expq.push_back(8'h3C);
        @(negedge clk);
        wr_valid = 1'b0;
        get_frame(f, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL rst_mid_rx: got no frame expected 3c");
        end else begin
            e = expq.pop_front();
            checks += 2;
            if (f.data !== e)        begin errors++; $display("FAIL rst_mid_data: got %02h expected %02h", f.data, e); end
            if (f.stop_bit !== 1'b1) begin errors++; $display("FAIL rst_mid_stop: got %b expected 1", f.stop_bit); end
            $display("rst_mid: clean frame data=%02h", f.data);
        end
        settle();
        checks++;
        if (rxq.size() != 0) begin errors++; $display("FAIL rst_mid_extra: got %0d stray frames expected 0", rxq.size()); end
    endtask

    task automatic test_two_stop();
        logic [6:0] vals [2];
        logic       exp_bits [2 * FB2];
        vals[0] = 7'h7F; vals[1] = 7'h15;
        for (int fr = 0; fr < 2; fr++) begin
            exp_bits[fr * FB2] = 1'b0;
            for (int i = 0; i < 7; i++) exp_bits[fr * FB2 + 1 + i] = vals[fr][i];
`ifdef UART_TX_PARITY_EN
            exp_bits[fr * FB2 + 8] = ^vals[fr];
`endif
            exp_bits[fr * FB2 + FB2 - 2] = 1'b1;
            exp_bits[fr * FB2 + FB2 - 1] = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            wr_data2 = vals[i]; wr_valid2 = 1'b1;
            @(negedge clk);
        end
        wr_valid2 = 1'b0;
        for (int i = 0; i < 2 * FB2 * BD; i++) begin
            checks += 2;
            if (tx2 !== exp_bits[i / BD]) begin
                errors++; $display("FAIL stop2_tx[%0d]: got %b expected %b", i, tx2, exp_bits[i / BD]);
            end
            if (busy2 !== 1'b1) begin
                errors++; $display("FAIL stop2_busy[%0d]: got %b expected 1", i, busy2);
            end
            @(negedge clk);
        end
        checks += 2;
        if (busy2 !== 1'b0) begin errors++; $display("FAIL stop2_end_busy: got %b expected 0", busy2); end
        if (tx2 !== 1'b1)   begin errors++; $display("FAIL stop2_end_tx: got %b expected 1", tx2); end
        $display("stop2: frames %02h %02h sent, %0d clocks each", vals[0], vals[1], FB2 * BD);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_no_gap();
        test_reset_mid_frame();
        test_two_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
